// File: rtl/sram_frame_arbiter.sv
// SRAM double-frame-buffer arbiter: blitter writes to the back buffer, line prefetch from the front buffer.
// Build option: define OVERRUN_CNT_EN to enable the saturating overrun_cnt counter.
module sram_frame_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 20
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [15:0]       pix_data,
  input  logic              wr_req,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              frame_clk,
  output logic              front_sel,
  output logic              fetch_overrun,
  output logic [15:0]       overrun_cnt,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RD_SETUP   = 3'd1;
  localparam logic [2:0] RD_CAPTURE = 3'd2;
  localparam logic [2:0] WR_SETUP   = 3'd3;
  localparam logic [2:0] WR_HOLD    = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [9:0]  prev_x, prev_y;
  logic        fetch_active;
  logic [9:0]  fetch_x, fetch_line;
  logic        cap_buf;
  logic [9:0]  cap_x;
  logic [15:0] wdata;
  logic        sram_en, flip_pending;
  logic [15:0] lbuf [0:1][0:H_ACTIVE-1];

  logic        trigger, next_vis, vb_start, wr_clip, flip_now, issue_rd, take_wr, blank;
  logic        src_active;
  logic [9:0]  next_line, src_x, src_line;

  always_comb begin
    trigger    = (DrawX == 10'(H_ACTIVE)) && (prev_x != 10'(H_ACTIVE));
    next_line  = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    next_vis   = next_line < 10'(V_ACTIVE);
    vb_start   = (DrawY == 10'(V_ACTIVE)) && (prev_y != 10'(V_ACTIVE));
    wr_clip    = (wr_x >= 10'(H_ACTIVE)) || (wr_y >= 10'(V_ACTIVE));
    blank      = (DrawX >= 10'(H_ACTIVE)) || (DrawY >= 10'(V_ACTIVE));
    // A trigger this cycle restarts the fetch at pixel 0 of the new line, in flight or not.
    src_active = trigger ? next_vis  : fetch_active;
    src_x      = trigger ? 10'd0     : fetch_x;
    src_line   = trigger ? next_line : fetch_line;
    flip_now   = (state == IDLE) && flip_pending;
    issue_rd   = src_active && (((state == IDLE) && !flip_pending) || (state == RD_CAPTURE));
    // wr_req/wr_ack: the request is held until a one-cycle wr_ack; while wr_ack is high the
    // still-asserted request is ignored, so each request is served exactly once.
    take_wr    = (state == IDLE) && !flip_pending && !src_active && wr_req && !wr_ack;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:       state_nxt = issue_rd ? RD_SETUP : ((take_wr && !wr_clip) ? WR_SETUP : IDLE);
      RD_SETUP:   state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = issue_rd ? RD_SETUP : IDLE;
      WR_SETUP:   state_nxt = WR_HOLD;
      WR_HOLD:    state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state         <= IDLE;
      prev_x        <= '0;
      prev_y        <= '0;
      fetch_active  <= 1'b0;
      fetch_x       <= '0;
      fetch_line    <= '0;
      cap_buf       <= 1'b0;
      cap_x         <= '0;
      wdata         <= '0;
      SRAM_ADDRESS  <= '0;
      wr_ack        <= 1'b0;
      swap_ack      <= 1'b0;
      frame_clk     <= 1'b0;
      front_sel     <= 1'b0;
      flip_pending  <= 1'b0;
      fetch_overrun <= 1'b0;
      sram_en       <= 1'b0;
      pix_data      <= '0;
    end else begin
      state     <= state_nxt;
      prev_x    <= DrawX;
      prev_y    <= DrawY;
      sram_en   <= 1'b1;
      wr_ack    <= (state == WR_HOLD) || (take_wr && wr_clip);
      frame_clk <= vb_start;
      swap_ack  <= flip_now;
      pix_data  <= blank ? 16'd0 : lbuf[DrawY[0]][DrawX];

      if (flip_now) front_sel <= ~front_sel;
      if (vb_start && swap_req) flip_pending <= 1'b1;
      else if (flip_now)        flip_pending <= 1'b0;

      if (trigger && fetch_active) fetch_overrun <= 1'b1;

      if (issue_rd) begin
        cap_buf      <= src_line[0];
        cap_x        <= src_x;
        fetch_x      <= src_x + 10'd1;
        fetch_line   <= src_line;
        fetch_active <= (src_x != 10'(H_ACTIVE - 1));
      end else if (trigger) begin
        fetch_x      <= '0;
        fetch_line   <= next_line;
        fetch_active <= next_vis;
      end

      if (issue_rd) begin
        SRAM_ADDRESS <= ADDR_W'({front_sel, src_line[8:0], src_x});
      end else if (take_wr && !wr_clip) begin
        SRAM_ADDRESS <= ADDR_W'({~front_sel, wr_y[8:0], wr_x});
        wdata        <= wr_data;
      end
    end
  end

  // Line buffers are deliberately not reset; they are fully rewritten by each fetch.
  always_ff @(posedge Clk) begin
    if (!RESET && (state == RD_CAPTURE)) lbuf[cap_buf][cap_x] <= SRAM_DQ;
  end

`ifdef OVERRUN_CNT_EN
  always_ff @(posedge Clk) begin
    if (RESET) overrun_cnt <= '0;
    else if (trigger && fetch_active && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
  end
`else
  assign overrun_cnt = '0;
`endif

  assign SRAM_CE_N = ~sram_en;
  assign SRAM_UB_N = ~sram_en;
  assign SRAM_LB_N = ~sram_en;
  assign SRAM_OE_N = ~((state == RD_SETUP) || (state == RD_CAPTURE));
  assign SRAM_WE_N = ~(state == WR_HOLD);
  assign SRAM_DQ   = ((state == WR_SETUP) || (state == WR_HOLD)) ? wdata : 16'bz;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter: vector tables for writes and pixels, plus hand sequences
// for fetch priority, vblank swap, overrun and reset during a write.
module tb_sram_frame_arbiter;

`ifdef OVERRUN_CNT_EN
  localparam logic [15:0] EXP_OVR = 16'd1;
`else
  localparam logic [15:0] EXP_OVR = 16'd0;
`endif

  logic        Clk = 1'b0;
  logic        RESET;
  logic [9:0]  DrawX, DrawY;
  logic [15:0] pix_data;
  logic        wr_req;
  logic [9:0]  wr_x, wr_y;
  logic [15:0] wr_data;
  logic        wr_ack, swap_req, swap_ack, frame_clk, front_sel, fetch_overrun;
  logic [15:0] overrun_cnt;
  wire  [15:0] SRAM_DQ;
  logic [19:0] SRAM_ADDRESS;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [2:0]  dbg_state;

  sram_frame_arbiter dut (
    .Clk(Clk), .RESET(RESET), .DrawX(DrawX), .DrawY(DrawY), .pix_data(pix_data),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_clk(frame_clk), .front_sel(front_sel),
    .fetch_overrun(fetch_overrun), .overrun_cnt(overrun_cnt), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDRESS(SRAM_ADDRESS), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .dbg_state(dbg_state)
  );

  // clock / SRAM model
  always #5 Clk = ~Clk;

  logic [15:0] mem [0:(1<<20)-1];
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDRESS] : 16'bz;

  int n_vec = 0, n_miss = 0;
  int we_cnt = 0, oe_cnt = 0, ack_cnt = 0, fclk_cnt = 0, sack_cnt = 0;
  logic [19:0] last_rd = '0, last_wr = '0;
  logic [35:0] exp_q[$];
  logic [35:0] sb_exp;

  // scoreboard / bus monitor
  always @(negedge Clk) begin
    if (!SRAM_WE_N) begin
      we_cnt++;
      last_wr = SRAM_ADDRESS;
      mem[SRAM_ADDRESS] = SRAM_DQ;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_write: got %h/%h, none expected", SRAM_ADDRESS, SRAM_DQ);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({SRAM_ADDRESS, SRAM_DQ} !== sb_exp) begin
          n_miss++;
          $display("FAIL sb_write: got %h expected %h", {SRAM_ADDRESS, SRAM_DQ}, sb_exp);
        end
      end
    end
    if (!SRAM_OE_N) begin
      oe_cnt++;
      last_rd = SRAM_ADDRESS;
    end
    if (wr_ack)    ack_cnt++;
    if (frame_clk) fclk_cnt++;
    if (swap_ack)  sack_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d,
                          output int lat);
    wr_x = x; wr_y = y; wr_data = d; wr_req = 1'b1;
    lat = 0;
    while (!wr_ack && lat < 2000) begin
      step();
      lat++;
    end
    wr_req = 1'b0;
  endtask

  // driver / vector tables
  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
    logic [19:0] addr;
    int          lat;
    int          we;
  } wr_vec_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] pix;
  } px_vec_t;

  wr_vec_t wv[6];
  px_vec_t pv[8];

  initial begin
    int lat, w0, o0, a0, f0, s0;

    wv[0] = '{10'd5,    10'd7,   16'hABCD, 20'h81C05, 3, 1};
    wv[1] = '{10'd640,  10'd7,   16'hABCD, 20'h00000, 1, 0};
    wv[2] = '{10'd639,  10'd479, 16'h1234, 20'hF7E7F, 3, 1};
    wv[3] = '{10'd0,    10'd480, 16'h4321, 20'h00000, 1, 0};
    wv[4] = '{10'd0,    10'd0,   16'h5555, 20'h80000, 3, 1};
    wv[5] = '{10'd1023, 10'd0,   16'h6666, 20'h00000, 1, 0};

    pv[0] = '{10'd0,    10'd1,   16'd0};
    pv[1] = '{10'd1,    10'd1,   16'd1};
    pv[2] = '{10'd5,    10'd1,   16'd5};
    pv[3] = '{10'd320,  10'd1,   16'd320};
    pv[4] = '{10'd639,  10'd1,   16'd639};
    pv[5] = '{10'd700,  10'd1,   16'd0};
    pv[6] = '{10'd1023, 10'd1,   16'd0};
    pv[7] = '{10'd100,  10'd480, 16'd0};

    for (int x = 0; x < 640; x++) mem[(1 << 10) | x] = 16'(x);

    // reset block
    RESET = 1'b1; DrawX = '0; DrawY = '0; wr_req = 1'b0; wr_x = '0; wr_y = '0;
    wr_data = '0; swap_req = 1'b0;
    step(3);
    check("rst_sram_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    check("rst_addr", SRAM_ADDRESS, 20'h0);
    check("rst_flags", {wr_ack, swap_ack, frame_clk, front_sel, fetch_overrun}, 5'h0);
    check("rst_cnt_pix", {overrun_cnt, pix_data}, 32'h0);
    check("rst_state", dbg_state, 3'd0);
    RESET = 1'b0;
    step();
    check("ce_after_rst", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N}, 5'b00011);

    // write vectors, including clipping boundaries
    for (int i = 0; i < 6; i++) begin
      w0 = we_cnt; a0 = ack_cnt;
      if (wv[i].we == 1) exp_q.push_back({wv[i].addr, wv[i].d});
      do_write(wv[i].x, wv[i].y, wv[i].d, lat);
      check("wr_latency", lat, wv[i].lat);
      step();
      check("wr_ack_pulse", wr_ack, 1'b0);
      check("wr_we_cycles", we_cnt - w0, wv[i].we);
      check("wr_ack_count", ack_cnt - a0, 1);
      if (wv[i].we == 1) check("wr_addr", last_wr, wv[i].addr);
    end

    // line fetch of line 1 from buffer 0
    DrawY = 10'd0; DrawX = 10'd639;
    step();
    o0 = oe_cnt;
    DrawX = 10'd640;
    step(1280);
    check("fetch_reads", oe_cnt - o0, 1280);
    check("fetch_last_addr", last_rd, 20'h0067F);
    step(4);
    check("fetch_no_extra", oe_cnt - o0, 1280);

    for (int i = 0; i < 8; i++) begin
      DrawX = pv[i].x; DrawY = pv[i].y;
      step();
      check("pix", pix_data, pv[i].pix);
    end

    // fetch beats a simultaneous write
    DrawY = 10'd2; DrawX = 10'd639;
    step();
    o0 = oe_cnt;
    exp_q.push_back({20'h8280A, 16'hBEEF});
    DrawX = 10'd640;
    do_write(10'd10, 10'd10, 16'hBEEF, lat);
    check("prio_wr_latency", lat, 1284);
    check("prio_reads", oe_cnt - o0, 1280);
    check("prio_wr_addr", last_wr, 20'h8280A);
    check("prio_no_overrun", fetch_overrun, 1'b0);
    step();

    // swap at vblank
    DrawX = 10'd0; swap_req = 1'b1;
    s0 = sack_cnt; f0 = fclk_cnt;
    for (int y = 100; y < 480; y++) begin
      DrawY = 10'(y);
      step();
    end
    check("no_early_swap", {sack_cnt - s0, 31'(front_sel)}, 0);
    DrawY = 10'd480;
    step();
    check("vb_frame_clk", {frame_clk, swap_ack, front_sel}, 3'b100);
    step();
    check("vb_swap_ack", {frame_clk, swap_ack, front_sel}, 3'b011);
    step();
    check("vb_swap_done", {frame_clk, swap_ack, front_sel}, 3'b001);
    swap_req = 1'b0;
    step(3);
    check("vb_pulse_counts", {fclk_cnt - f0, sack_cnt - s0}, {32'd1, 32'd1});

    exp_q.push_back({20'h01003, 16'h7777});
    do_write(10'd3, 10'd4, 16'h7777, lat);
    check("post_swap_wr_lat", lat, 3);
    check("post_swap_wr_addr", last_wr, 20'h01003);
    step();

    // last line does not fetch; line V_TOTAL-1 fetches line 0 from buffer 1
    DrawY = 10'd479; DrawX = 10'd639;
    step();
    o0 = oe_cnt;
    DrawX = 10'd640;
    step(10);
    check("no_fetch_line480", oe_cnt - o0, 0);
    DrawY = 10'd524; DrawX = 10'd639;
    step();
    o0 = oe_cnt;
    DrawX = 10'd640;
    step(1280);
    check("wrap_fetch_reads", oe_cnt - o0, 1280);
    check("wrap_fetch_addr", last_rd, 20'h8027F);
    step(4);

    // overrun
    DrawY = 10'd10; DrawX = 10'd639;
    step();
    DrawX = 10'd640;
    step(500);
    check("ovr_before", fetch_overrun, 1'b0);
    DrawX = 10'd641;
    step();
    DrawX = 10'd640;
    step();
    check("ovr_set", fetch_overrun, 1'b1);
    check("ovr_cnt", overrun_cnt, EXP_OVR);
    step(1300);
    check("ovr_sticky", fetch_overrun, 1'b1);
    check("ovr_cnt_hold", overrun_cnt, EXP_OVR);
    check("ovr_refetch_addr", last_rd, 20'h82E7F);

    // reset during WR_HOLD
    a0 = ack_cnt;
    exp_q.push_back({20'h05014, 16'h9999});
    wr_x = 10'd20; wr_y = 10'd20; wr_data = 16'h9999; wr_req = 1'b1;
    step();
    check("mid_wr_setup_we", SRAM_WE_N, 1'b1);
    step();
    check("mid_wr_hold_we", SRAM_WE_N, 1'b0);
    RESET = 1'b1; wr_req = 1'b0;
    step();
    check("rst_mid_ctl", {SRAM_WE_N, SRAM_OE_N, wr_ack, front_sel}, 4'b1100);
    step(2);
    RESET = 1'b0;
    step(3);
    check("rst_mid_no_ack", ack_cnt - a0, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
